// File: rtl/poci_pkg.sv
// poci_pkg: shared constants, receiver state type and frame length helper for the POCI link
package poci_pkg;
  localparam int ADDR_W_DEFAULT = 8;
  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_END} rx_state_t;
  function automatic int frame_len(input int addr_w, input bit parity);
    return addr_w + int'(parity);
  endfunction
endpackage

// File: rtl/address_deserializer_if.sv
// address_deserializer_if: serial link inputs and parallel word outputs of the address receiver
interface address_deserializer_if
  import poci_pkg::*;
#(parameter int ADDR_W = ADDR_W_DEFAULT);
  logic serial_in;
  logic frame_en;
  logic [ADDR_W-1:0] addr;
  logic addr_valid;
  logic frame_err;
  logic parity_err;
  modport master (output serial_in, frame_en, input addr, addr_valid, frame_err, parity_err);
  modport slave (input serial_in, frame_en, output addr, addr_valid, frame_err, parity_err);
endinterface

// File: rtl/poci_bit_counter.sv
// poci_bit_counter: saturating count of sampled bits with sync clear and terminal-count flag
module poci_bit_counter #(
  parameter int FLEN = 8,
  localparam int CW = $clog2(FLEN + 1)
) (
  input  logic          sclk,
  input  logic          rstn,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          tc
);
  assign tc = cnt == CW'(FLEN);
  // a clear that coincides with a sampled bit restarts the count at one
  always_ff @(posedge sclk or negedge rstn)
    if (!rstn) cnt <= '0;
    else cnt <= clr ? CW'(en) : (en && !tc) ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/address_deserializer.sv
// address_deserializer: LSB-first serial-to-parallel receiver; PARITY_CHECK_EN adds a trailing even parity bit
module address_deserializer
  import poci_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input logic sclk,
  input logic rstn,
  address_deserializer_if.slave bus
);
`ifdef PARITY_CHECK_EN
  localparam int FLEN = frame_len(ADDR_W, 1'b1);
`else
  localparam int FLEN = frame_len(ADDR_W, 1'b0);
`endif
  localparam int CW = $clog2(FLEN + 1);
  rx_state_t state;
  logic [ADDR_W-1:0] sh, next_sh, addr;
  logic [CW-1:0] cnt;
  logic tc, addr_valid, frame_err, extra, payload, last;
  poci_bit_counter #(.FLEN(FLEN)) u_cnt (
    .sclk(sclk),
    .rstn(rstn),
    .clr(state == IDLE),
    .en(bus.frame_en && state != WAIT_END),
    .cnt(cnt),
    .tc(tc)
  );
  // new bits enter at the top so the first bit received ends up in bit 0
  always_comb begin
    next_sh = sh >> 1;
    next_sh[ADDR_W-1] = bus.serial_in;
  end
  assign payload = state == IDLE || cnt < CW'(ADDR_W);
  assign last = state == IDLE ? FLEN == 1 : cnt == CW'(FLEN - 1);
  assign bus.addr = addr;
  assign bus.addr_valid = addr_valid;
  assign bus.frame_err = frame_err;
`ifdef PARITY_CHECK_EN
  logic par, parity_err;
  assign bus.parity_err = parity_err;
`else
  assign bus.parity_err = 1'b0;
`endif
  // frame FSM: assemble the word, publish it on the last bit and flag short, long or bad-parity frames
  always_ff @(posedge sclk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      sh <= '0;
      addr <= '0;
      addr_valid <= 1'b0;
      frame_err <= 1'b0;
      extra <= 1'b0;
`ifdef PARITY_CHECK_EN
      par <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      addr_valid <= 1'b0;
      frame_err <= 1'b0;
`ifdef PARITY_CHECK_EN
      parity_err <= 1'b0;
`endif
      case (state)
        IDLE, SHIFT:
          if (!bus.frame_en) begin
            frame_err <= state == SHIFT && !tc;
            state <= IDLE;
          end else begin
            if (payload) begin
              sh <= next_sh;
`ifdef PARITY_CHECK_EN
              par <= (state == IDLE ? 1'b0 : par) ^ bus.serial_in;
`endif
            end
            if (last) begin
`ifdef PARITY_CHECK_EN
              if (par ^ bus.serial_in) parity_err <= 1'b1;
              else begin
                addr <= sh;
                addr_valid <= 1'b1;
              end
`else
              addr <= next_sh;
              addr_valid <= 1'b1;
`endif
              extra <= 1'b0;
              state <= WAIT_END;
            end else state <= SHIFT;
          end
        default:
          if (!bus.frame_en) state <= IDLE;
          else if (!extra) begin
            frame_err <= 1'b1;
            extra <= 1'b1;
          end
      endcase
    end
endmodule

// File: tb/tb_address_deserializer.sv
// tb_address_deserializer: table, hand-written and random frames checked against a frame-level model
module tb_address_deserializer;
  import poci_pkg::*;
  localparam int W = 8;
`ifdef PARITY_CHECK_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FLEN = frame_len(W, PAR);

  typedef struct {
    logic [7:0] word;
    int len;
    int extra;
    logic [6:0] tail;
    int gap;
    int e_nv;
    int e_nf;
    logic [7:0] e_addr;
  } vec_t;

  logic sclk = 1'b0;
  logic rstn = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_addr = 8'h00;
  int nv, nf, np, tv, tf, cyc;
  vec_t tbl[7];

  address_deserializer_if #(.ADDR_W(W)) bus ();
  address_deserializer #(.ADDR_W(W)) dut (.sclk(sclk), .rstn(rstn), .bus(bus));

  always #5 sclk = ~sclk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic si, input logic en);
    @(negedge sclk);
    bus.serial_in = si;
    bus.frame_en = en;
    @(posedge sclk);
    #1;
    cyc++;
    check("strobe_exclusive", int'(bus.addr_valid) + int'(bus.frame_err) + int'(bus.parity_err) <= 1, 1);
    if (bus.addr_valid) begin nv++; tv = cyc; end
    if (bus.frame_err) begin if (nf == 0) tf = cyc; nf++; end
    if (bus.parity_err) np++;
  endtask

  task automatic send(input logic [15:0] bits, input int len, input int gap);
    nv = 0; nf = 0; np = 0; tv = 0; tf = 0; cyc = 0;
    for (int i = 0; i < len; i++) step(bits[i], 1'b1);
    for (int g = 0; g < gap; g++) step(1'b0, 1'b0);
  endtask

  function automatic logic [15:0] mk(input logic [7:0] word, input bit par_ok, input logic [6:0] tail);
    logic [15:0] b;
    b = {8'h00, word};
    if (PAR) b[8] = ^word ^ !par_ok;
    b = b | ({9'h000, tail} << FLEN);
    return b;
  endfunction

  task automatic expect_frame(input logic [15:0] bits, input int len, input string tag);
    logic [7:0] word;
    bit full, good;
    word = bits[7:0];
    full = len >= FLEN;
    good = full && (!PAR || bits[8] == ^word);
    if (good) exp_addr = word;
    check({tag, "_valid_count"}, nv, int'(good));
    check({tag, "_valid_cycle"}, tv, good ? FLEN : 0);
    check({tag, "_ferr_count"}, nf, int'(len != FLEN));
    check({tag, "_ferr_cycle"}, tf, len < FLEN ? len + 1 : len > FLEN ? FLEN + 1 : 0);
    check({tag, "_perr_count"}, np, int'(full && !good));
    check({tag, "_addr"}, int'(bus.addr), int'(exp_addr));
  endtask

  initial begin
    logic [15:0] bits;
    int len;
    bus.serial_in = 1'b0;
    bus.frame_en = 1'b0;
    tbl[0] = '{8'hA5, 0, 0, 7'h00, 2, 1, 0, 8'hA5};
    tbl[1] = '{8'h1F, 5, 0, 7'h00, 2, 0, 1, 8'hA5};
    tbl[2] = '{8'h3C, 0, 2, 7'h03, 2, 1, 1, 8'h3C};
    tbl[3] = '{8'hFF, 0, 0, 7'h00, 1, 1, 0, 8'hFF};
    tbl[4] = '{8'h00, 0, 0, 7'h00, 1, 1, 0, 8'h00};
    tbl[5] = '{8'h6B, 1, 0, 7'h00, 1, 0, 1, 8'h00};
    tbl[6] = '{8'h5A, 0, 1, 7'h01, 3, 1, 1, 8'h5A};

    repeat (3) @(negedge sclk);
    #1;
    check("reset_addr", int'(bus.addr), 0);
    check("reset_strobes", int'({bus.addr_valid, bus.frame_err, bus.parity_err}), 0);
    @(negedge sclk);
    rstn = 1'b1;
    step(1'b0, 1'b0);

    foreach (tbl[k]) begin
      len = (tbl[k].len == 0 ? FLEN : tbl[k].len) + tbl[k].extra;
      bits = mk(tbl[k].word, 1'b1, tbl[k].tail);
      send(bits, len, tbl[k].gap);
      check($sformatf("tbl%0d_valid", k), nv, tbl[k].e_nv);
      check($sformatf("tbl%0d_ferr", k), nf, tbl[k].e_nf);
      check($sformatf("tbl%0d_addr", k), int'(bus.addr), int'(tbl[k].e_addr));
      expect_frame(bits, len, $sformatf("tbl%0d", k));
    end

    send(mk(8'h81, 1'b1, 7'h00), 4, 0);
    #1;
    rstn = 1'b0;
    bus.frame_en = 1'b0;
    #1;
    check("async_reset_addr", int'(bus.addr), 0);
    check("async_reset_strobes", int'({bus.addr_valid, bus.frame_err, bus.parity_err}), 0);
    exp_addr = 8'h00;
    repeat (2) @(negedge sclk);
    rstn = 1'b1;
    step(1'b0, 1'b0);
    check("post_reset_no_ferr", nf, 0);
    bits = mk(8'h81, 1'b1, 7'h00);
    send(bits, FLEN, 2);
    check("after_reset_addr", int'(bus.addr), 8'h81);
    expect_frame(bits, FLEN, "after_reset");

`ifdef PARITY_CHECK_EN
    bits = mk(8'h07, 1'b1, 7'h00);
    send(bits, FLEN, 1);
    check("par_good_addr", int'(bus.addr), 8'h07);
    expect_frame(bits, FLEN, "par_good");
    bits = mk(8'h12, 1'b1, 7'h00);
    send(bits, FLEN, 1);
    expect_frame(bits, FLEN, "par_prev");
    bits = mk(8'h07, 1'b0, 7'h00);
    send(bits, FLEN, 1);
    check("par_bad_perr", np, 1);
    check("par_bad_hold", int'(bus.addr), 8'h12);
    expect_frame(bits, FLEN, "par_bad");
`endif

    for (int k = 0; k < 40; k++) begin
      int r;
      r = $urandom_range(0, 19);
      len = r < 14 ? FLEN : r < 17 ? $urandom_range(1, FLEN - 1) : $urandom_range(FLEN + 1, FLEN + 3);
      bits = mk(8'($urandom), $urandom_range(0, 4) != 0, 7'($urandom));
      send(bits, len, $urandom_range(1, 3));
      expect_frame(bits, len, $sformatf("rnd%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
